// File: rtl/mem_access_seq.sv
// SRAM access sequencer: turns a one-cycle read/write request into timed active-low
// CE/OE/WE strobes, holds address/data for the whole access and returns a Ready pulse.
module mem_access_seq #(
    parameter int READ_WAIT  = 2,
    parameter int WRITE_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req_Rd,
    input  logic        Req_Wr,
    input  logic [15:0] Addr_In,
    input  logic [15:0] Data_W,
    input  logic [15:0] Data_from_SRAM,
    output logic [15:0] Data_R,
    output logic        Ready,
    output logic        Busy,
    output logic [19:0] ADDR,
    output logic [15:0] Data_to_SRAM,
    output logic        Drive_En,
    output logic        Mem_CE,
    output logic        Mem_OE,
    output logic        Mem_WE,
    output logic        Mem_UB,
    output logic        Mem_LB
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_HOLD  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [3:0] RD_LOAD = 4'(READ_WAIT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_WAIT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_next_cnt;
    logic        w_latch_addr;
    logic        w_latch_wdata;
    logic        w_capture;

    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_data_r;

    logic        w_ce_n;
    logic        w_oe_n;
    logic        w_we_n;
    logic        w_drive;
    logic        w_busy;
    logic        w_ready;
    logic        r_ce_n;
    logic        r_oe_n;
    logic        r_we_n;
    logic        r_drive;
    logic        r_busy;
    logic        r_ready;

    // State and wait-counter register
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next-state, counter and latch-enable decode
    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_latch_addr  = 1'b0;
        w_latch_wdata = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Read has priority when both requests arrive together
                if (Req_Rd) begin
                    w_next_state = S_RD;
                    w_next_cnt   = RD_LOAD;
                    w_latch_addr = 1'b1;
                end else if (Req_Wr) begin
                    w_next_state  = S_WR_SETUP;
                    w_latch_addr  = 1'b1;
                    w_latch_wdata = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RD: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = S_DONE;
                    w_capture    = 1'b1;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            S_WR_SETUP: begin
                w_next_state = S_WR_PULSE;
                w_next_cnt   = WR_LOAD;
            end
            S_WR_PULSE: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = S_WR_HOLD;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            S_WR_HOLD: w_next_state = S_DONE;
            S_DONE:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Strobe decode from the upcoming state so the outputs can be registered
    always_comb begin
        w_ce_n  = 1'b1;
        w_oe_n  = 1'b1;
        w_we_n  = 1'b1;
        w_drive = 1'b0;
        w_busy  = 1'b1;
        w_ready = 1'b0;
        case (w_next_state)
            S_IDLE: w_busy = 1'b0;
            S_RD: begin
                w_ce_n = 1'b0;
                w_oe_n = 1'b0;
            end
            S_WR_SETUP: begin
                w_ce_n  = 1'b0;
                w_drive = 1'b1;
            end
            S_WR_PULSE: begin
                w_ce_n  = 1'b0;
                w_we_n  = 1'b0;
                w_drive = 1'b1;
            end
            S_WR_HOLD: begin
                w_ce_n  = 1'b0;
                w_drive = 1'b1;
            end
            S_DONE:  w_ready = 1'b1;
            default: w_busy  = 1'b0;
        endcase
    end

    // Registered strobes; reset forces them inactive on the same edge
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_drive <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_ce_n  <= w_ce_n;
            r_oe_n  <= w_oe_n;
            r_we_n  <= w_we_n;
            r_drive <= w_drive;
            r_busy  <= w_busy;
            r_ready <= w_ready;
        end
    end

    // Address / write-data latches and read-data capture
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_addr   <= 16'h0000;
            r_wdata  <= 16'h0000;
            r_data_r <= 16'h0000;
        end else begin
            if (w_latch_addr) begin
                r_addr <= Addr_In;
            end else begin
                r_addr <= r_addr;
            end
            if (w_latch_wdata) begin
                r_wdata <= Data_W;
            end else begin
                r_wdata <= r_wdata;
            end
            if (w_capture) begin
                r_data_r <= Data_from_SRAM;
            end else begin
                r_data_r <= r_data_r;
            end
        end
    end

    assign Data_R       = r_data_r;
    assign Ready        = r_ready;
    assign Busy         = r_busy;
    assign ADDR         = {4'b0000, r_addr};
    assign Data_to_SRAM = r_wdata;
    assign Drive_En     = r_drive;
    assign Mem_CE       = r_ce_n;
    assign Mem_OE       = r_oe_n;
    assign Mem_WE       = r_we_n;
    assign Mem_UB       = 1'b0;
    assign Mem_LB       = 1'b0;

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: two instances (2/2 and 1/15 wait states) on shared stimulus,
// checked every cycle against a transaction-offset reference model.
module tb_mem_access_seq;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req_Rd;
    logic        Req_Wr;
    logic [15:0] Addr_In;
    logic [15:0] Data_W;
    logic [15:0] Data_from_SRAM;

    logic [15:0] dr_o [2];
    logic [19:0] ad_o [2];
    logic [15:0] ds_o [2];
    logic        rdy_o[2];
    logic        bsy_o[2];
    logic        drv_o[2];
    logic        ce_o [2];
    logic        oe_o [2];
    logic        we_o [2];
    logic        ub_o [2];
    logic        lb_o [2];

    int checks   = 0;
    int failures = 0;

    // model state per instance: t = cycles since acceptance (0 = idle)
    int          rw_p[2] = '{2, 1};
    int          ww_p[2] = '{2, 15};
    int          t_m [2];
    bit          isrd[2];
    logic [15:0] am  [2];
    logic [15:0] wm  [2];
    logic [15:0] drm [2];

    always #5 Clk = ~Clk;

    mem_access_seq #(.READ_WAIT(2), .WRITE_WAIT(2)) u_dut0 (
        .Clk(Clk), .Reset(Reset), .Req_Rd(Req_Rd), .Req_Wr(Req_Wr),
        .Addr_In(Addr_In), .Data_W(Data_W), .Data_from_SRAM(Data_from_SRAM),
        .Data_R(dr_o[0]), .Ready(rdy_o[0]), .Busy(bsy_o[0]), .ADDR(ad_o[0]),
        .Data_to_SRAM(ds_o[0]), .Drive_En(drv_o[0]), .Mem_CE(ce_o[0]),
        .Mem_OE(oe_o[0]), .Mem_WE(we_o[0]), .Mem_UB(ub_o[0]), .Mem_LB(lb_o[0])
    );

    mem_access_seq #(.READ_WAIT(1), .WRITE_WAIT(15)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .Req_Rd(Req_Rd), .Req_Wr(Req_Wr),
        .Addr_In(Addr_In), .Data_W(Data_W), .Data_from_SRAM(Data_from_SRAM),
        .Data_R(dr_o[1]), .Ready(rdy_o[1]), .Busy(bsy_o[1]), .ADDR(ad_o[1]),
        .Data_to_SRAM(ds_o[1]), .Drive_En(drv_o[1]), .Mem_CE(ce_o[1]),
        .Mem_OE(oe_o[1]), .Mem_WE(we_o[1]), .Mem_UB(ub_o[1]), .Mem_LB(lb_o[1])
    );

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%h expected=%h at %0t", tag, k, obs, exp, $time);
        end
    endtask

    // Advance each instance's model by one edge using the inputs about to be sampled
    task automatic model_step(input int k);
        int len;
        if (!Reset) begin
            t_m[k] = 0;
            am[k]  = 16'h0000;
            wm[k]  = 16'h0000;
            drm[k] = 16'h0000;
        end else if (t_m[k] == 0) begin
            if (Req_Rd) begin
                isrd[k] = 1'b1;
                t_m[k]  = 1;
                am[k]   = Addr_In;
            end else if (Req_Wr) begin
                isrd[k] = 1'b0;
                t_m[k]  = 1;
                am[k]   = Addr_In;
                wm[k]   = Data_W;
            end
        end else begin
            len = isrd[k] ? rw_p[k] + 1 : ww_p[k] + 3;
            if (isrd[k] && t_m[k] == rw_p[k]) drm[k] = Data_from_SRAM;
            t_m[k] = (t_m[k] == len) ? 0 : t_m[k] + 1;
        end
    endtask

    task automatic model_check(input int k);
        int   t;
        int   len;
        logic e_ce, e_oe, e_we, e_drv;
        t     = t_m[k];
        len   = isrd[k] ? rw_p[k] + 1 : ww_p[k] + 3;
        e_ce  = 1'b1;
        e_oe  = 1'b1;
        e_we  = 1'b1;
        e_drv = 1'b0;
        if (t != 0 && isrd[k] && t <= rw_p[k]) begin
            e_ce = 1'b0;
            e_oe = 1'b0;
        end
        if (t != 0 && !isrd[k] && t <= ww_p[k] + 2) begin
            e_ce  = 1'b0;
            e_drv = 1'b1;
            e_we  = (t >= 2 && t <= ww_p[k] + 1) ? 1'b0 : 1'b1;
        end
        chk("ce",    k, 32'(ce_o[k]),  32'(e_ce));
        chk("oe",    k, 32'(oe_o[k]),  32'(e_oe));
        chk("we",    k, 32'(we_o[k]),  32'(e_we));
        chk("drive", k, 32'(drv_o[k]), 32'(e_drv));
        chk("busy",  k, 32'(bsy_o[k]), 32'(t != 0));
        chk("ready", k, 32'(rdy_o[k]), 32'(t != 0 && t == len));
        chk("addr",  k, 32'(ad_o[k]),  {16'h0000, am[k]});
        chk("wdata", k, 32'(ds_o[k]),  32'(wm[k]));
        chk("rdata", k, 32'(dr_o[k]),  32'(drm[k]));
        chk("ublb",  k, 32'({ub_o[k], lb_o[k]}), 32'd0);
    endtask

    task automatic cyc();
        model_step(0);
        model_step(1);
        @(posedge Clk);
        #1;
        model_check(0);
        model_check(1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        Reset          = 1'b0;
        Req_Rd         = 1'b0;
        Req_Wr         = 1'b0;
        Addr_In        = 16'h0000;
        Data_W         = 16'h0000;
        Data_from_SRAM = 16'h0000;
        for (int k = 0; k < 2; k++) begin
            t_m[k] = 0; isrd[k] = 1'b0; am[k] = 16'h0; wm[k] = 16'h0; drm[k] = 16'h0;
        end

        // reset
        idle(2);
        chk("rst_rdata", 0, 32'(dr_o[0]), 32'd0);
        Reset = 1'b1;
        idle(1);

        // directed read of 0x0012 returning 0xBEEF
        Addr_In        = 16'h0012;
        Data_from_SRAM = 16'hBEEF;
        Req_Rd         = 1'b1;
        cyc();
        Req_Rd  = 1'b0;
        Addr_In = 16'h5555;
        idle(1);
        chk("rd_oe_low_c2", 0, 32'(oe_o[0]), 32'd0);
        idle(1);
        chk("rd_ready_c3", 0, 32'(rdy_o[0]), 32'd1);
        chk("rd_data", 0, 32'(dr_o[0]), 32'h0000BEEF);
        chk("rd_addr", 0, 32'(ad_o[0]), 32'h00012);
        idle(3);

        // directed write; Data_W changes right after acceptance
        Addr_In = 16'h0034;
        Data_W  = 16'h1234;
        Req_Wr  = 1'b1;
        cyc();
        Req_Wr = 1'b0;
        Data_W = 16'hFFFF;
        idle(4);
        chk("wr_ready_c5", 0, 32'(rdy_o[0]), 32'd1);
        chk("wr_hold_data", 0, 32'(ds_o[0]), 32'h00001234);
        idle(16);

        // simultaneous read+write: read wins
        Addr_In        = 16'h0A0B;
        Data_W         = 16'hCAFE;
        Data_from_SRAM = 16'h7E57;
        Req_Rd         = 1'b1;
        Req_Wr         = 1'b1;
        cyc();
        Req_Rd = 1'b0;
        Req_Wr = 1'b0;
        idle(6);

        // reset in the middle of WR_PULSE
        Req_Wr = 1'b1;
        cyc();
        Req_Wr = 1'b0;
        cyc();
        chk("wr_pulse_we", 0, 32'(we_o[0]), 32'd0);
        Reset = 1'b0;
        cyc();
        chk("rst_mid_we", 0, 32'(we_o[0]), 32'd1);
        chk("rst_mid_busy", 0, 32'(bsy_o[0]), 32'd0);
        chk("rst_mid_rdata", 0, 32'(dr_o[0]), 32'd0);
        Reset = 1'b1;
        idle(3);

        // Req_Rd held high: back-to-back reads
        Req_Rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            Data_from_SRAM = 16'($urandom);
            Addr_In        = 16'($urandom);
            cyc();
        end
        Req_Rd = 1'b0;
        idle(4);

        // randomized traffic including occasional resets
        for (int i = 0; i < 600; i++) begin
            Reset          = ($urandom_range(0, 79) != 0);
            Req_Rd         = ($urandom_range(0, 3) == 0);
            Req_Wr         = ($urandom_range(0, 2) == 0);
            Addr_In        = 16'($urandom);
            Data_W         = 16'($urandom);
            Data_from_SRAM = 16'($urandom);
            cyc();
        end
        Reset  = 1'b1;
        Req_Rd = 1'b0;
        Req_Wr = 1'b0;
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
